tmr_run_ctrl: RTL
=================

// Module: tmr_run_ctrl
// PURPOSE
//  Run-control and prescaler stage directly upstream of the timer counter (cnt_v1).
//  Produces the counter's enable tick (en) and wrap limit (max).
//  Watches the counter value to detect wrap. Supports one-shot and periodic modes
//  with a sticky wrap interrupt. Shadow registers keep the config seen by the counter stable while running.
// PARAMETERS
//  PSC_WIDTH  8  width of prescaler divide value; tick period = cfg_psc+1 cycles
//  CNT_WIDTH  4  width of counter value / limit; must match downstream counter
// PORTS
//  clk          in   1          system clock, rising edge
//  rstn         in   1          asynchronous active-low reset
//  cfg_psc      in   PSC_WIDTH  prescaler divide value (0 = tick every cycle)
//  cfg_max      in   CNT_WIDTH  counter wrap limit
//  cfg_oneshot  in   1          1 = stop after first wrap, 0 = periodic
//  start        in   1          1-cycle pulse: load shadows, (re)start
//  stop         in   1          1-cycle pulse: halt
//  irq_clr      in   1          1-cycle pulse: clear irq
//  cnt          in   CNT_WIDTH  current downstream counter value
//  en           out  1          counter enable tick, to counter en
//  max          out  CNT_WIDTH  registered wrap limit, to counter max
//  busy         out  1          1 while in RUN
//  irq          out  1          sticky wrap interrupt
// BEHAVIOUR
//  - One clock (clk); reset asynchronous active-low (rstn). Reset: state=IDLE, psc_cnt=0,
//    psc_sh=0, max=0, en=0, busy=0, irq=0.
//  - Counter contract: on each cycle with en=1, counter goes cnt+1, or 0 when cnt==max.
//  - States: IDLE, RUN. busy = (state==RUN), registered state.
//  - IDLE --start--> RUN: psc_sh<=cfg_psc, max<=cfg_max, oneshot_sh<=cfg_oneshot, psc_cnt<=0.
//  - en = RUN && (psc_cnt==psc_sh). Combinational from registers only, so glitch-free.
//    psc_cnt <= en ? 0 : psc_cnt+1 while RUN; held at 0 in IDLE.
//  - First en: in cycle cfg_psc after the start edge. Cycle 0 is the first cycle after the edge,
//    so psc=0 gives en in that cycle. Steady period psc+1 cycles.
//  - wrap = en && (cnt==max). On wrap: irq<=1.
//    Periodic: reload psc_sh/max/oneshot_sh from cfg_* (config changes only at wrap boundary).
//    One-shot: RUN->IDLE; en low from next cycle.
//  - max==0: every en is a wrap.
//  - start while RUN: restart as from IDLE (shadows reloaded, psc_cnt<=0).
//    The counter is NOT cleared by this block.
//  - stop: RUN->IDLE at that edge, en=0 from next cycle; cnt/irq untouched.
//    stop in IDLE: no effect.
//  - start && stop same cycle: stop wins (result IDLE).
//  - wrap && irq_clr same cycle: set wins (irq stays 1).
//  - wrap && stop same cycle: irq set, state IDLE.
//  - cfg_* changes while RUN take effect only at next wrap (periodic) or next start.
//  - Async reset mid-RUN: all outputs to reset values immediately; en falls with rstn.
//  - psc_cnt compare uses equality; psc_cnt never exceeds psc_sh (no overflow path).
// STRUCTURE
//  - Package tmr_pkg: typedef enum logic {IDLE, RUN} tmr_state_e; default PSC_WIDTH/CNT_WIDTH
//    localparams shared with cnt_v1 bench.
//  - One sub-module tmr_psc: prescaler counter
//    (clk, rstn, run, clr, div[PSC_WIDTH] -> tick). Top holds FSM, shadows, irq.
// TESTING (bench drives cnt from a cnt_v1 instance fed by en/max)
//  1. Reset: rstn low mid-run -> en=0, max=0, busy=0, irq=0 immediately. Stay so until start.
//  2. Periodic cfg_psc=3, cfg_max=4, start -> en high every 4th cycle, first in cycle 3.
//     cnt 0..4,0; irq=1 on the edge after the 5th en. busy stays 1.
//  3. One-shot cfg_psc=0, cfg_max=2 -> en high 3 consecutive cycles, then busy=0, en=0.
//     cnt ends 0; irq=1.
//  4. Shadow update: periodic psc=1, max=3. Change cfg_max to 1 mid-count ->
//     max stays 3 until wrap, then 1.
//  5. Collisions: start&&stop -> stays IDLE. wrap&&irq_clr -> irq=1.
//     Next irq_clr alone -> irq=0.
//  6. Restart: start while RUN with psc_cnt=2 (cfg_psc=5) -> psc_cnt=0, next en 5 cycles later.
//     cnt unchanged.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared types and default widths for the timer run-control stage and the
// downstream counter bench.
package tmr_pkg;

   localparam int PSC_WIDTH_DEF = 8;
   localparam int CNT_WIDTH_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tmr_state_e;

endpackage

// File: rtl/tmr_psc.sv
// Prescaler: emits one tick every div+1 cycles while run is high and
// restarts its count from zero on clr.
module tmr_psc
   import tmr_pkg::*;
#(
   parameter int PSC_WIDTH = PSC_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 run,
   input  logic                 clr,
   input  logic [PSC_WIDTH-1:0] div,
   output logic                 tick
);

   logic [PSC_WIDTH-1:0] psc_cnt;

   // Decoded from registers only, so the tick cannot glitch on input changes.
   assign tick = run && (psc_cnt == div);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         psc_cnt <= '0;
      end else if (!run || clr || tick) begin
         psc_cnt <= '0;
      end else begin
         psc_cnt <= psc_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/tmr_run_ctrl.sv
// Run control for the timer counter: drives the counter enable tick and wrap
// limit, tracks wrap, and raises a sticky interrupt.
//
//   state | meaning
//   IDLE  | halted, en low, prescaler held at zero
//   RUN   | prescaler counting, en pulses every psc_sh+1 cycles
module tmr_run_ctrl
   import tmr_pkg::*;
#(
   parameter int PSC_WIDTH = PSC_WIDTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [PSC_WIDTH-1:0] cfg_psc,
   input  logic [CNT_WIDTH-1:0] cfg_max,
   input  logic                 cfg_oneshot,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 irq_clr,
   input  logic [CNT_WIDTH-1:0] cnt,
   output logic                 en,
   output logic [CNT_WIDTH-1:0] max,
   output logic                 busy,
   output logic                 irq
);

   tmr_state_e           state_q;
   tmr_state_e           state_d;
   logic [PSC_WIDTH-1:0] psc_sh;
   logic                 oneshot_sh;
   logic                 load_sh;
   logic                 wrap;

   assign busy = (state_q == RUN);
   assign wrap = en && (cnt == max);

   tmr_psc #(
      .PSC_WIDTH (PSC_WIDTH)
   ) u_psc (
      .clk  (clk),
      .rstn (rstn),
      .run  (busy),
      .clr  (start || stop),
      .div  (psc_sh),
      .tick (en)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // stop dominates start; a periodic wrap is the only point where a running
   // timer picks up new configuration.
   always_comb begin
      state_d = state_q;
      load_sh = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d = RUN;
               load_sh = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (start) begin
               load_sh = 1'b1;
            end else if (wrap) begin
               if (oneshot_sh) begin
                  state_d = IDLE;
               end else begin
                  load_sh = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         psc_sh     <= '0;
         max        <= '0;
         oneshot_sh <= 1'b0;
      end else if (load_sh) begin
         psc_sh     <= cfg_psc;
         max        <= cfg_max;
         oneshot_sh <= cfg_oneshot;
      end
   end

   // Set has priority over clear so a wrap is never lost.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         irq <= 1'b0;
      end else if (wrap) begin
         irq <= 1'b1;
      end else if (irq_clr) begin
         irq <= 1'b0;
      end
   end

endmodule
